// File: rtl/sync_frame_ctr_pkg.sv
// Shared helpers for the frame position counter slice.
package sync_frame_ctr_pkg;

  // ceil(log2(n)) with a floor of 1, so tiny parameters still yield a legal vector width
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_frame_ctr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ce) begin
      if (clr) begin
        count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sync_frame_ctr.sv
// Frame position counter driven by a one-cycle sync strobe, with lock tracking
// and a saturating count of misaligned syncs.
module sync_frame_ctr
  import sync_frame_ctr_pkg::*;
#(
  parameter int unsigned FRAME_LEN     = 256,
  parameter int unsigned ERR_CNT_BITS  = 16,
  parameter bit          RESYNC_ON_ERR = 1'b1,
  parameter int unsigned MAX_MISS      = 4,
  localparam int unsigned POS_BITS     = clog2_min1(FRAME_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    sync_in,
  input  logic                    err_clr,
  output logic [POS_BITS-1:0]     pos,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic                    locked,
  output logic                    sync_err,
  output logic [ERR_CNT_BITS-1:0] err_cnt
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam int unsigned MissBits = clog2_min1(MAX_MISS + 1);
  localparam logic [POS_BITS-1:0] PosLast = POS_BITS'(FRAME_LEN - 1);
  localparam logic [MissBits-1:0] MissMax = MissBits'(MAX_MISS);

  logic [0:0]          state_q, state_d;
  logic [POS_BITS-1:0] pos_q, pos_d;
  logic [MissBits-1:0] miss_q, miss_d;
  logic                sync_err_q;
  logic                at_last;
  logic                misaligned;

  assign at_last    = (pos_q == PosLast);
  assign misaligned = ce && (state_q == StLocked) && sync_in && !at_last;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    miss_d  = miss_q;
    if (ce) begin
      case (state_q)
        StIdle: begin
          if (sync_in) begin
            state_d = StLocked;
            pos_d   = '0;
          end
        end
        StLocked: begin
          pos_d = at_last ? '0 : pos_q + 1'b1;
          if (sync_in) begin
            if (at_last) begin
              miss_d = '0;
            end else if (RESYNC_ON_ERR) begin
              pos_d = '0;
            end
          end else if (at_last && (MAX_MISS != 0)) begin
            // Dropping lock parks pos at 0 and rearms the miss counter for the next lock
            if (miss_q + 1'b1 == MissMax) begin
              state_d = StIdle;
              pos_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pos_q      <= '0;
      miss_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      miss_q     <= miss_d;
      // Not gated by ce: the pulse always lasts exactly one clk
      sync_err_q <= misaligned;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_BITS)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .inc   (misaligned),
    .clr   (err_clr),
    .count (err_cnt)
  );

  assign pos         = pos_q;
  assign locked      = (state_q == StLocked);
  assign frame_start = locked && (pos_q == '0);
  assign frame_end   = locked && at_last;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_sync_frame_ctr.sv
// Directed bench: FRAME_LEN=8, MAX_MISS=4, 2-bit error counter; a second instance
// with RESYNC_ON_ERR=0 shares the stimulus for the non-resync misaligned case.
module tb_sync_frame_ctr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic sync_in = 1'b0;
  logic err_clr = 1'b0;

  logic [2:0] a_pos, b_pos;
  logic       a_fs, a_fe, a_locked, a_serr;
  logic       b_fs, b_fe, b_locked, b_serr;
  logic [1:0] a_ecnt, b_ecnt;

  int n_checks = 0;
  int n_errs = 0;

  always #5 clk = ~clk;

  sync_frame_ctr #(
    .FRAME_LEN     (8),
    .ERR_CNT_BITS  (2),
    .RESYNC_ON_ERR (1'b1),
    .MAX_MISS      (4)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .sync_in     (sync_in),
    .err_clr     (err_clr),
    .pos         (a_pos),
    .frame_start (a_fs),
    .frame_end   (a_fe),
    .locked      (a_locked),
    .sync_err    (a_serr),
    .err_cnt     (a_ecnt)
  );

  sync_frame_ctr #(
    .FRAME_LEN     (8),
    .ERR_CNT_BITS  (2),
    .RESYNC_ON_ERR (1'b0),
    .MAX_MISS      (4)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .sync_in     (sync_in),
    .err_clr     (err_clr),
    .pos         (b_pos),
    .frame_start (b_fs),
    .frame_end   (b_fe),
    .locked      (b_locked),
    .sync_err    (b_serr),
    .err_cnt     (b_ecnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_pos", a_pos, 0);
    check("rst_locked", a_locked, 0);
    check("rst_fs", a_fs, 0);
    check("rst_fe", a_fe, 0);
    check("rst_serr", a_serr, 0);
    check("rst_ecnt", a_ecnt, 0);
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b1;

    // Idle without sync: no lock, pos held at 0
    for (int i = 0; i < 10; i++) tick();
    check("idle_locked", a_locked, 0);
    check("idle_pos", a_pos, 0);

    // Lock on sync
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("lock_pos", a_pos, 0);
    check("lock_locked", a_locked, 1);
    check("lock_fs", a_fs, 1);
    check("lock_serr", a_serr, 0);

    // Two aligned frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 1; i < 8; i++) begin
        tick();
        check("run_pos", a_pos, i);
        check("run_fe", a_fe, (i == 7) ? 1 : 0);
      end
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      check("align_pos", a_pos, 0);
      check("align_fs", a_fs, 1);
      check("align_serr", a_serr, 0);
      check("align_ecnt", a_ecnt, 0);
      check("align_locked", a_locked, 1);
      check("align_b_pos", b_pos, 0);
    end

    // Misaligned sync at pos 3
    for (int i = 0; i < 3; i++) tick();
    check("pre_mis_pos", a_pos, 3);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("mis_a_pos", a_pos, 0);
    check("mis_a_serr", a_serr, 1);
    check("mis_a_ecnt", a_ecnt, 1);
    check("mis_b_pos", b_pos, 4);
    check("mis_b_serr", b_serr, 1);
    check("mis_b_ecnt", b_ecnt, 1);
    check("mis_b_locked", b_locked, 1);
    tick();
    check("mis_serr_clear", a_serr, 0);
    check("mis_pos_next", a_pos, 1);

    // ce gating: pos and errors frozen, sync ignored while ce=0
    ce = 1'b0;
    tick();
    check("ce0_pos", a_pos, 1);
    ce = 1'b1;
    tick();
    check("ce1_pos", a_pos, 2);
    ce = 1'b0;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("ce0_sync_pos", a_pos, 2);
    check("ce0_sync_serr", a_serr, 0);
    check("ce0_sync_ecnt", a_ecnt, 1);
    ce = 1'b1;
    tick();
    check("ce1_pos2", a_pos, 3);

    // sync_err clears on the next edge even with ce low
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("mis2_serr", a_serr, 1);
    check("mis2_ecnt", a_ecnt, 2);
    check("mis2_pos", a_pos, 0);
    ce = 1'b0;
    tick();
    check("serr_clr_ce0", a_serr, 0);
    check("hold_pos_ce0", a_pos, 0);
    ce = 1'b1;

    // Saturation of the 2-bit error counter
    sync_in = 1'b1;
    tick();
    check("sat_ecnt3", a_ecnt, 3);
    tick();
    check("sat_hold", a_ecnt, 3);
    check("sat_serr", a_serr, 1);
    err_clr = 1'b1;
    tick();
    sync_in = 1'b0;
    err_clr = 1'b0;
    check("clr_wins_ecnt", a_ecnt, 0);
    check("clr_serr", a_serr, 1);
    check("clr_pos", a_pos, 0);

    // Missing syncs: four missed boundaries drop lock
    for (int i = 0; i < 31; i++) tick();
    check("miss3_locked", a_locked, 1);
    check("miss3_pos", a_pos, 7);
    tick();
    check("drop_locked", a_locked, 0);
    check("drop_pos", a_pos, 0);
    check("drop_fs", a_fs, 0);
    check("drop_serr", a_serr, 0);
    check("drop_ecnt", a_ecnt, 0);

    // Relock without error
    tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("relock_locked", a_locked, 1);
    check("relock_pos", a_pos, 0);
    check("relock_serr", a_serr, 0);

    // Async reset mid-frame, checked before the next edge
    for (int i = 0; i < 3; i++) tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("pre_rst_serr", a_serr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pos", a_pos, 0);
    check("arst_locked", a_locked, 0);
    check("arst_fs", a_fs, 0);
    check("arst_serr", a_serr, 0);
    check("arst_ecnt", a_ecnt, 0);
    check("arst_b_locked", b_locked, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_frame_ctr.md
# sync_frame_ctr

Downstream consumer of the delayed sync pulse. Turns the one-cycle sync strobe into a free-running frame position counter with frame_start/frame_end markers. Tracks frame lock: misaligned syncs raise an error pulse and increment a saturating error count, and lock is dropped after repeated missing syncs. Sits between the sync delay line and any per-channel/per-bin datapath logic that needs a frame index.

## Interface
- FRAME_LEN, 256, clocks per frame; must be ≥ 2.
- ERR_CNT_BITS, 16, width of the saturating error counter.
- RESYNC_ON_ERR, 1, 1 = a misaligned sync restarts the frame; 0 = the sync is flagged and ignored.
- MAX_MISS, 4, consecutive frame boundaries without a sync before lock is dropped; 0 = never drop.
- Derived localparam POS_BITS = `log2(FRAME_LEN)`, minimum 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds and sync_in is ignored.
- sync_in  in  1  one-cycle sync strobe from the delay stage.
- err_clr  in  1  synchronous clear of err_cnt, qualified by ce.
- pos  out  POS_BITS  current frame position, 0..FRAME_LEN-1.
- frame_start  out  1  locked && pos==0.
- frame_end  out  1  locked && pos==FRAME_LEN-1.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse on a misaligned sync.
- err_cnt  out  ERR_CNT_BITS  saturating count of misaligned syncs.

## Operation
- States:
  - IDLE: no lock; pos held at 0.
  - LOCKED: pos free-runs.
- A boundary cycle is LOCKED && pos==FRAME_LEN-1 && ce.
- IDLE:
  - sync_in && ce → pos←0, state←LOCKED.
  - A sync in IDLE is never an error.
- LOCKED, per ce cycle:
  - pos increments, wrapping FRAME_LEN-1 → 0.
  - sync_in on a boundary cycle: aligned; miss counter ←0.
  - sync_in on a non-boundary cycle: misaligned.
    - sync_err pulses and err_cnt increments, saturating at all-ones.
    - If RESYNC_ON_ERR=1: pos←0.
    - If RESYNC_ON_ERR=0: pos continues normally.
    - The miss counter is unaffected.
  - Boundary cycle without sync_in (MAX_MISS>0):
    - Miss counter increments.
    - If the increment reaches MAX_MISS: state←IDLE, pos←0, miss counter←0.
- err_clr && ce → err_cnt←0. If a misaligned sync arrives in the same cycle, the clear wins and err_cnt=0.
- frame_start and frame_end are decoded combinationally from registered pos/state. They are glitch-free relative to clk.

## Timing
- Reset values: pos=0, locked=0, frame_start=0, frame_end=0, sync_err=0, err_cnt=0; state IDLE; miss counter 0.
- Reset is asynchronous assert. It dominates every input, including mid-frame.
- Latency: sync_in sampled at edge N (ce=1) → pos=0 and frame_start=1 visible after edge N.
- sync_err is registered and asserted for exactly one clk after the offending edge. It clears on the next edge regardless of ce.
- ce low: pos, state, counters and err_cnt hold; sync_in and err_clr are ignored.
- Aligned steady state: sync every FRAME_LEN ce-cycles keeps frame_start coincident with the sync-induced restart, with no error.
- Drop-to-IDLE occurs on the MAX_MISS-th missed boundary edge. locked falls after that edge.

## Structure
- Single Verilog module. Use the shared `log2` macro from the common math include for POS_BITS.
- State encoding as module localparams. No shared package content is needed.
- Natural sub-module: sat_counter (parameterised width, inc/clr/ce, saturates at all-ones), used for err_cnt and reusable elsewhere in general_lib.

## Test plan
- Reset, then sync_in at cycle 10, FRAME_LEN=8 → pos=0 and locked=1 after cycle 10; frame_start every 8 cycles; pos sequence 0..7 repeating.
- Syncs every 8 cycles, aligned with pos==7 → sync_err never pulses, err_cnt=0, locked stays 1.
- Sync at pos==3 with RESYNC_ON_ERR=1 → sync_err one cycle, err_cnt=1, next pos=0. Same stimulus with RESYNC_ON_ERR=0 → err_cnt=1, next pos=4.
- Lock, then stop syncs with MAX_MISS=4 → locked falls after the 4th missed boundary, pos=0. A new sync relocks with no error.
- ce toggled 1/0 alternately during lock → pos advances only on ce cycles; a sync_in while ce=0 is ignored (no error, no restart).
- ERR_CNT_BITS=2, five misaligned syncs → err_cnt saturates at 3. err_clr coincident with a 6th misaligned sync → err_cnt=0, and sync_err still pulses. Async rst mid-frame → all outputs 0 immediately.
